// File: rtl/gpa_spi_serialiser.sv
// rtl/gpa_spi_serialiser.sv - multi-channel parallel SPI serialiser for GPA DAC boards
module gpa_spi_serialiser #(
    parameter int NCH  = 4,
    parameter int DW   = 24,
    parameter int DIVW = 6,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [CHW-1:0]  ch_i,
    input  logic [DW-1:0]   word_i,
    input  logic            bcast_i,
    input  logic [DIVW-1:0] spi_clk_div_i,
    input  logic            ldac_en_i,
    output logic            sclk_o,
    output logic            syncn_o,
    output logic            ldacn_o,
    output logic [NCH-1:0]  sdo_o,
    output logic            busy_o,
    output logic [NCH-1:0]  data_lost_o
);

    localparam int BCW = $clog2(DW);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_LOAD} state_e;

    state_e                    state_q, state_d;
    logic [NCH-1:0][DW-1:0]    staging_q, staging_d;
    logic [NCH-1:0][DW-1:0]    shift_q, shift_d;
    logic [NCH-1:0]            present_q, present_d;
    logic [NCH-1:0]            lost_q, lost_d;
    logic                      pending_q, pending_d;
    logic [BCW-1:0]            bit_q, bit_d;
    logic [DIVW-1:0]           hc_q, hc_d;
    logic [DIVW-1:0]           div_q, div_d;
    logic                      sclk_q, sclk_d;
    logic                      syncn_q, syncn_d;
    logic                      ldacn_q, ldacn_d;
    logic [NCH-1:0]            sdo_q, sdo_d;
    logic                      busy_q, busy_d;
    logic [NCH-1:0]            wr_sel;
    logic                      load;

    // Out-of-range channel numbers match no select line and are dropped.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_sel[i] = valid_i && (ch_i == CHW'(i));
        end
    end

    always_comb begin
        state_d   = state_q;
        staging_d = staging_q;
        shift_d   = shift_q;
        present_d = present_q;
        lost_d    = lost_q;
        pending_d = pending_q;
        bit_d     = bit_q;
        hc_d      = hc_q;
        div_d     = div_q;
        sclk_d    = sclk_q;
        syncn_d   = syncn_q;
        ldacn_d   = ldac_en_i;
        sdo_d     = sdo_q;
        load      = 1'b0;

        case (state_q)
            S_IDLE: begin
                sclk_d  = 1'b0;
                syncn_d = 1'b1;
                if (pending_q) begin
                    load    = 1'b1;
                    state_d = S_SHIFT;
                    shift_d = staging_q;
                    syncn_d = 1'b0;
                    bit_d   = BCW'(DW - 1);
                    hc_d    = '0;
                    div_d   = spi_clk_div_i;
                    for (int i = 0; i < NCH; i++) begin
                        sdo_d[i] = staging_q[i][DW-1];
                    end
                end
            end
            S_SHIFT: begin
                if (hc_q == div_q) begin
                    hc_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_q == '0) begin
                        sclk_d  = 1'b0;
                        syncn_d = 1'b1;
                        sdo_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        // Data only moves on the falling SCLK edge so it is stable at the rise.
                        sclk_d = 1'b0;
                        bit_d  = bit_q - 1'b1;
                        for (int i = 0; i < NCH; i++) begin
                            shift_d[i] = shift_q[i] << 1;
                            sdo_d[i]   = shift_q[i][DW-2];
                        end
                    end
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
            S_GAP: begin
                if (hc_q == div_q) begin
                    hc_d = '0;
                    if (ldac_en_i) begin
                        ldacn_d = 1'b0;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
            S_LOAD: begin
                ldacn_d = 1'b0;
                if (hc_q == div_q) begin
                    hc_d    = '0;
                    ldacn_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            pending_d = 1'b0;
            present_d = '0;
            lost_d    = '0;
        end

        // A write landing on the load cycle belongs to the next frame and is never an overwrite.
        for (int i = 0; i < NCH; i++) begin
            if (wr_sel[i]) begin
                staging_d[i] = word_i;
                if (present_q[i] && !load) begin
                    lost_d[i] = 1'b1;
                end
                present_d[i] = 1'b1;
            end
        end

        if ((|wr_sel) && bcast_i) begin
            pending_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            staging_q <= '0;
            shift_q   <= '0;
            present_q <= '0;
            lost_q    <= '0;
            pending_q <= 1'b0;
            bit_q     <= '0;
            hc_q      <= '0;
            div_q     <= '0;
            sclk_q    <= 1'b0;
            syncn_q   <= 1'b1;
            ldacn_q   <= 1'b1;
            sdo_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            staging_q <= staging_d;
            shift_q   <= shift_d;
            present_q <= present_d;
            lost_q    <= lost_d;
            pending_q <= pending_d;
            bit_q     <= bit_d;
            hc_q      <= hc_d;
            div_q     <= div_d;
            sclk_q    <= sclk_d;
            syncn_q   <= syncn_d;
            ldacn_q   <= ldacn_d;
            sdo_q     <= sdo_d;
            busy_q    <= busy_d;
        end
    end

    assign sclk_o      = sclk_q;
    assign syncn_o     = syncn_q;
    assign ldacn_o     = ldacn_q;
    assign sdo_o       = sdo_q;
    assign busy_o      = busy_q;
    assign data_lost_o = lost_q;

endmodule

// File: tb/tb_gpa_spi_serialiser.sv
// tb/tb_gpa_spi_serialiser.sv - scoreboard bench for gpa_spi_serialiser
module tb_gpa_spi_serialiser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic [1:0]  ch_i = '0;
    logic [23:0] word_i = '0;
    logic        bcast_i = 1'b0;
    logic [5:0]  spi_clk_div_i = 6'd3;
    logic        ldac_en_i = 1'b0;
    logic        sclk_o, syncn_o, ldacn_o, busy_o;
    logic [3:0]  sdo_o, data_lost_o;

    logic        valid5 = 1'b0;
    logic [2:0]  ch5 = '0;
    logic        sclk5, syncn5, ldacn5, busy5;
    logic [4:0]  sdo5, lost5;

    typedef struct {
        logic [3:0][23:0] w;
        int               len;
    } frame_t;

    frame_t           exp_q[$];
    logic [3:0][23:0] mdl = '0;
    int               n_vec = 0;
    int               n_bad = 0;

    always #5 clk = ~clk;

    gpa_spi_serialiser #(.NCH(4), .DW(24), .DIVW(6)) u_dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ch_i(ch_i), .word_i(word_i),
        .bcast_i(bcast_i), .spi_clk_div_i(spi_clk_div_i), .ldac_en_i(ldac_en_i),
        .sclk_o(sclk_o), .syncn_o(syncn_o), .ldacn_o(ldacn_o), .sdo_o(sdo_o),
        .busy_o(busy_o), .data_lost_o(data_lost_o)
    );

    gpa_spi_serialiser #(.NCH(5), .DW(24), .DIVW(6)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid5), .ch_i(ch5), .word_i(word_i),
        .bcast_i(bcast_i), .spi_clk_div_i(6'd0), .ldac_en_i(1'b0),
        .sclk_o(sclk5), .syncn_o(syncn5), .ldacn_o(ldacn5), .sdo_o(sdo5),
        .busy_o(busy5), .data_lost_o(lost5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input int c, input logic [23:0] w, input logic b);
        valid_i = 1'b1;
        ch_i    = c[1:0];
        word_i  = w;
        bcast_i = b;
        mdl[c]  = w;
        if (b) exp_q.push_back('{w: mdl, len: 2 * (int'(spi_clk_div_i) + 1) * 24});
        @(negedge clk);
        valid_i = 1'b0;
        bcast_i = 1'b0;
    endtask

    task automatic wr5(input logic [2:0] c, input logic [23:0] w, input logic b);
        valid5  = 1'b1;
        ch5     = c;
        word_i  = w;
        bcast_i = b;
        @(negedge clk);
        valid5  = 1'b0;
        bcast_i = 1'b0;
    endtask

    task automatic wait_syncn(input logic lvl);
        int n = 0;
        while (syncn_o !== lvl && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (syncn_o !== lvl) check("wait_syncn", syncn_o, lvl);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_o || exp_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) check("wait_idle", busy_o, 0);
    endtask

    // Frame monitor: collects bits on each SCLK rise and pops the expected frame when SYNCn rises.
    initial begin
        logic [3:0][23:0] acc = '0;
        int     nbits = 0;
        int     nlow = 0;
        bit     in_frame = 0;
        logic   sclk_p = 1'b0;
        frame_t fr;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 0;
            end else if (!syncn_o) begin
                if (!in_frame) begin
                    in_frame = 1;
                    nbits = 0;
                    nlow = 0;
                end
                nlow++;
                if (sclk_o && !sclk_p) begin
                    for (int c = 0; c < 4; c++) acc[c] = {acc[c][22:0], sdo_o[c]};
                    nbits++;
                end
            end else if (in_frame) begin
                in_frame = 0;
                if (exp_q.size() == 0) begin
                    check("frame_unexpected", exp_q.size(), 1);
                end else begin
                    fr = exp_q.pop_front();
                    check("frame_bits", nbits, 24);
                    check("frame_len", nlow, fr.len);
                    for (int c = 0; c < 4; c++) check($sformatf("frame_ch%0d", c), acc[c], fr.w[c]);
                end
            end
            sclk_p = sclk_o;
        end
    end

    initial begin
        int n;
        bit seen;
        logic [4:0][23:0] got5;
        int b;
        logic p;

        repeat (3) @(negedge clk);
        check("rst_sclk", sclk_o, 0);
        check("rst_syncn", syncn_o, 1);
        check("rst_ldacn", ldacn_o, 1);
        check("rst_sdo", sdo_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_lost", data_lost_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ldacn_transparent", ldacn_o, 0);

        // Basic frame, D=3
        wr(0, 24'h800001, 0);
        wr(1, 24'h7FFFFF, 0);
        wr(2, 24'h000000, 0);
        wr(3, 24'hA5A5A5, 1);
        check("syncn_pre", syncn_o, 1);
        @(negedge clk);
        check("syncn_fall", syncn_o, 0);
        check("busy_rise", busy_o, 1);
        wait_syncn(1);
        n = 0;
        seen = 0;
        while (busy_o && n < 100) begin
            if (ldacn_o) seen = 1;
            @(negedge clk);
            n++;
        end
        check("busy_fall_lat", n, 4);
        check("ldacn_held", seen, 0);
        wait_idle();

        // Overwrite flags
        wr(1, 24'h000001, 0);
        check("lost_first", data_lost_o, 4'b0000);
        wr(1, 24'h000001, 0);
        check("lost_second", data_lost_o, 4'b0010);
        wr(1, 24'h3C3C3C, 1);
        check("lost_hold", data_lost_o, 4'b0010);
        @(negedge clk);
        check("lost_clear", data_lost_o, 4'b0000);
        check("syncn_fall2", syncn_o, 0);
        wait_idle();

        // LDAC pulse, D=1
        ldac_en_i = 1'b1;
        spi_clk_div_i = 6'd1;
        @(negedge clk);
        check("ldacn_idle_en", ldacn_o, 1);
        wr(0, 24'h0F0F0F, 1);
        wait_syncn(0);
        wait_syncn(1);
        n = 0;
        while (ldacn_o && n < 50) begin @(negedge clk); n++; end
        check("ldac_gap", n, 2);
        n = 0;
        while (!ldacn_o && n < 50) begin @(negedge clk); n++; end
        check("ldac_width", n, 2);
        check("busy_after_load", busy_o, 0);
        wait_idle();

        // Broadcast queued during SHIFT
        ldac_en_i = 1'b0;
        spi_clk_div_i = 6'd3;
        @(negedge clk);
        wr(0, 24'hC0FFEE, 1);
        wait_syncn(0);
        repeat (80) @(negedge clk);
        wr(2, 24'h123456, 1);
        n = 0;
        while (busy_o && n < 400) begin @(negedge clk); n++; end
        n = 0;
        while (!busy_o && n < 10) begin @(negedge clk); n++; end
        check("requeue_gap", n, 1);
        check("requeue_syncn", syncn_o, 0);
        wait_idle();

        // Reset mid-frame (around bit 10)
        wr(1, 24'hFFFFFF, 1);
        wait_syncn(0);
        repeat (8 * 13) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_sclk", sclk_o, 0);
        check("midrst_syncn", syncn_o, 1);
        check("midrst_sdo", sdo_o, 0);
        check("midrst_busy", busy_o, 0);
        exp_q.delete();
        mdl = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wr(0, 24'h000000, 1);
        wait_idle();

        // D=0 frame
        spi_clk_div_i = 6'd0;
        @(negedge clk);
        wr(3, 24'h5A5A5A, 1);
        wait_idle();

        // Out-of-range channel on a 5-channel instance
        wr5(3'd5, 24'hFFFFFF, 0);
        check("oor_flag1", lost5, 5'b00000);
        wr5(3'd5, 24'hFFFFFF, 0);
        check("oor_flag2", lost5, 5'b00000);
        wr5(3'd4, 24'h000000, 0);
        wr5(3'd4, 24'h000000, 0);
        check("ch4_flag", lost5, 5'b10000);
        wr5(3'd0, 24'h111111, 1);
        n = 0;
        while (syncn5 && n < 20) begin @(negedge clk); n++; end
        check("d5_syncn", syncn5, 0);
        check("d5_lost_clear", lost5, 5'b00000);
        got5 = '0;
        b = 0;
        n = 0;
        p = 1'b0;
        while (b < 24 && n < 200) begin
            if (sclk5 && !p) begin
                for (int c = 0; c < 5; c++) got5[c] = {got5[c][22:0], sdo5[c]};
                b++;
            end
            p = sclk5;
            @(negedge clk);
            n++;
        end
        check("d5_bits", b, 24);
        check("d5_ch0", got5[0], 24'h111111);
        for (int c = 1; c < 5; c++) check($sformatf("d5_ch%0d", c), got5[c], 24'h000000);
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
